// File: rtl/spi_slave.sv
// SPI mode-0 slave: 2-flop synchronizers on the SPI pins, an IDLE/SHIFT FSM,
// a one-word transmit holding buffer and back-to-back words within a frame.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              aborted,
    output logic              busy
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic              sclk_m, sclk_s, sclk_d;
    logic              nss_m, nss_s, nss_d;
    logic              mosi_m, mosi_s;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh, tx_buf;
    logic              pending, done;
    logic              sclk_rise, sclk_fall, nss_rise, nss_fall, load;

    // Two-flop synchronizers plus one delay flop for edge detection;
    // the idle levels are loaded in reset so no false edge appears at release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
            nss_m  <= 1'b1; nss_s  <= 1'b1; nss_d  <= 1'b1;
            mosi_m <= 1'b0; mosi_s <= 1'b0;
        end else begin
            sclk_m <= sclk; sclk_s <= sclk_m; sclk_d <= sclk_s;
            nss_m  <= nss;  nss_s  <= nss_m;  nss_d  <= nss_s;
            mosi_m <= mosi; mosi_s <= mosi_m;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign nss_rise  = nss_s & ~nss_d;
    assign nss_fall  = ~nss_s & nss_d;

    // Tx shift register reloads at frame start and after each completed word.
    assign load = (state == IDLE  && nss_fall) ||
                  (state == SHIFT && !nss_rise && sclk_fall && done);

    // Main FSM, shift registers, holding buffer and output pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_buf   <= '0;
            pending  <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            aborted  <= 1'b0;

            // Handshake and load never collide on pending: a handshake needs
            // pending clear, a consuming load needs it set.
            if (tx_valid && !pending) begin
                tx_buf  <= tx_data;
                pending <= 1'b1;
            end
            if (load) begin
                if (pending) begin
                    tx_sh   <= tx_buf;
                    pending <= 1'b0;
                end else begin
                    tx_sh <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (nss_fall) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (nss_rise) begin
                        state   <= IDLE;
                        aborted <= (cnt != '0);
                        cnt     <= '0;
                        done    <= 1'b0;
                        rx_sh   <= '0;
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
                        if (cnt == CW'(DATA_W - 1)) begin
                            cnt      <= '0;
                            rx_data  <= {rx_sh[DATA_W-2:0], mosi_s};
                            rx_valid <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (done)
                            done <= 1'b0;
                        else
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == SHIFT);
    assign miso_oe  = busy;
    assign miso     = busy & tx_sh[DATA_W-1];
    assign tx_ready = ~pending;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8, SPI word length in bits (MSB first).
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sclk  input  1  SPI serial clock from the master, asynchronous to clock.
REQ-005 nss  input  1  SPI chip select, active-low, asynchronous to clock.
REQ-006 mosi  input  1  serial data from the master.
REQ-007 miso  output  1  serial data to the master.
REQ-008 miso_oe  output  1  high while the slave is selected and driving miso.
REQ-009 tx_data  input  DATA_W  next word to return to the master.
REQ-010 tx_valid  input  1  tx_data is valid; accepted when tx_valid and tx_ready are both high.
REQ-011 tx_ready  output  1  high while the transmit holding buffer is empty.
REQ-012 rx_data  output  DATA_W  last complete word received; held until the next complete word.
REQ-013 rx_valid  output  1  one-clock pulse per complete received word.
REQ-014 aborted  output  1  one-clock pulse when nss deasserts mid-word.
REQ-015 busy  output  1  high while the FSM is in SHIFT.

Function
REQ-016 sclk, nss and mosi SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signals; sclk frequency SHALL be at most clock/4.
REQ-017 The protocol is SPI mode 0: mosi sampled on sclk rising edge, miso updated on sclk falling edge, MSB first.
REQ-018 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on a synchronized nss falling edge; SHIFT->IDLE on a synchronized nss rising edge.
REQ-019 On IDLE->SHIFT, the tx shift register SHALL load tx_buf and clear its pending flag if pending, else load all zeros; the bit counter SHALL clear to 0.
REQ-020 Transmit holding: on handshake, tx_buf <= tx_data and the pending flag is set; tx_ready = not pending.
REQ-021 Same-cycle handshake and load: the load SHALL use the pre-handshake state (0 if not pending); the new word SHALL stay pending for the next load.
REQ-022 miso SHALL equal the tx shift register MSB in SHIFT and 0 in IDLE; miso_oe SHALL be high exactly in SHIFT.
REQ-023 On each sclk rising edge in SHIFT: synchronized mosi shifts into the rx shift register LSB; the bit counter increments modulo DATA_W.
REQ-024 On the sclk rising edge that makes the counter wrap from DATA_W-1 to 0: rx_data <= completed word and rx_valid pulses the next clock; a word-done flag is set.
REQ-025 On each sclk falling edge in SHIFT with word-done clear, the tx shift register SHALL shift left one bit (zero fill).
REQ-026 On an sclk falling edge with word-done set, the tx shift register SHALL instead reload per REQ-019 and word-done SHALL clear, so back-to-back words within one nss frame are supported.
REQ-027 A synchronized nss rising edge with bit counter not 0: aborted pulses one clock; the partial word is discarded; rx_data and rx_valid are unaffected.
REQ-028 On any nss rising edge: the counter and word-done clear; a still-pending tx_buf SHALL remain pending.
REQ-029 sclk edges while in IDLE SHALL be ignored.
REQ-030 Latency: rx_valid SHALL assert 3 clocks after the raw sclk rising edge completing the word (2 sync plus 1 register).

Reset
REQ-031 While reset is high: FSM=IDLE, counter=0, shift registers=0, tx_buf=0, pending=0, word-done=0.
REQ-032 While reset is high: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, aborted=0, busy=0, and the synchronizers hold nss=1, sclk=0, mosi=0.
REQ-033 Reset asserted mid-frame SHALL discard all in-flight data without rx_valid or aborted.
REQ-034 After reset, a new frame SHALL require a fresh nss falling edge.

Verification
REQ-035 Single word: tx 0xA5 accepted, master sends 0x3C -> master reads 0xA5; rx_data=0x3C; exactly one rx_valid; tx_ready=1.
REQ-036 Back-to-back: tx 0x11, then 0x22 queued during word 1, master sends 0xF0,0x0F under one nss -> master reads 0x11,0x22; two rx_valid with 0xF0 then 0x0F.
REQ-037 Underrun: no tx queued, master sends 0x81 -> master reads 0x00; rx_data=0x81.
REQ-038 Abort: nss rises after 5 bits of 0xFF -> one aborted pulse; no rx_valid; rx_data unchanged; FSM in IDLE.
REQ-039 Mid-frame reset after 3 bits -> all outputs at reset values; next full frame sending 0x5A gives rx_data=0x5A.
REQ-040 Same-cycle tx_valid with nss fall, no prior pending -> first word reads 0x00; the new word is returned in the next word.
